// File: rtl/tc_mul_if.sv
// tc_mul_if: operand/result bundle for the tc_mul multiplier.
//   master drives en_i, valid_i, rm_i, a_i, b_i and samples out_*;
//   slave (the multiplier) is the reverse.
//   en_i          pipeline enable, 0 = every stage holds
//   valid_i       a_i/b_i carry a product request
//   rm_i          rounding mode: 000 RNE, 001 RTZ, 010 RUP, 011 RDN, others RNE
//   a_i, b_i      {sign, exp[EXPWIDTH-1:0], frac[INPC-1:0]}
//   out_valid_o   result/flags hold a product
//   out_result_o  {sign, exp[EXPWIDTH-1:0], frac[PRECISION-1:0]}
//   out_fflags_o  {NV, DZ, OF, UF, NX}
interface tc_mul_if #(
  parameter int EXPWIDTH  = 5,
  parameter int INPC      = 10,
  parameter int PRECISION = 8
);
  logic                          en_i;
  logic                          valid_i;
  logic [2:0]                    rm_i;
  logic [EXPWIDTH+INPC:0]        a_i;
  logic [EXPWIDTH+INPC:0]        b_i;
  logic                          out_valid_o;
  logic [EXPWIDTH+PRECISION:0]   out_result_o;
  logic [4:0]                    out_fflags_o;

  modport master (
    output en_i, valid_i, rm_i, a_i, b_i,
    input  out_valid_o, out_result_o, out_fflags_o
  );

  modport slave (
    input  en_i, valid_i, rm_i, a_i, b_i,
    output out_valid_o, out_result_o, out_fflags_o
  );
endinterface

// File: rtl/tc_mul.sv
// tc_mul: 2-stage pipelined floating-point multiplier feeding the tc_add tree.
//   Stage 1 decodes/classifies the operands (DAZ), multiplies significands,
//   sums exponents. Stage 2 normalises, rounds to PRECISION fraction bits,
//   handles overflow/underflow (FTZ) and specials, and registers the outputs.
//   clk    clock
//   rst_n  synchronous reset, active low; clears every register, beats en_i
//   bus    tc_mul_if.slave: en_i/valid_i/rm_i/a_i/b_i in, out_* out
module tc_mul #(
  parameter int EXPWIDTH  = 5,
  parameter int INPC      = 10,
  parameter int PRECISION = 8
) (
  input logic    clk,
  input logic    rst_n,
  tc_mul_if.slave bus
);
  localparam int STAGES = 2;
  localparam int PW     = 2*INPC+2;       // raw significand product width
  localparam int EW     = EXPWIDTH+2;     // signed exponent width
  localparam int OW     = EXPWIDTH+PRECISION+1;
  localparam int BIAS   = (1 << (EXPWIDTH-1)) - 1;
  localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXPWIDTH) - 1);
  localparam logic signed [EW-1:0] EZERO  = '0;

  typedef struct packed {
    logic                 sign;
    logic signed [EW-1:0] exp;
    logic [PW-1:0]        prod;
    logic [2:0]           rm;
    logic                 is_nan;
    logic                 nv;
    logic                 is_inf;
    logic                 is_zero;
  } s1_t;

  s1_t s1_d, s1_q;
  logic [STAGES:1] vld_pipe;
  logic [OW-1:0]   res_d, res_q;
  logic [4:0]      flg_d, flg_q;

  // ---------------- stage 1: decode / multiply ----------------
  logic                sa, sb;
  logic [EXPWIDTH-1:0] ea, eb;
  logic [INPC-1:0]     fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, inf_x_zero;

  assign {sa, ea, fa} = bus.a_i;
  assign {sb, eb, fb} = bus.b_i;

  // exp==0 covers both true zero and subnormal (flushed to zero on input)
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign a_nan  = (&ea) && (fa != '0);
  assign b_nan  = (&eb) && (fb != '0);
  assign a_snan = a_nan && !fa[INPC-1];
  assign b_snan = b_nan && !fb[INPC-1];
  assign inf_x_zero = (a_inf && b_zero) || (b_inf && a_zero);

  always_comb begin
    s1_d         = '0;
    s1_d.sign    = sa ^ sb;
    // modular EW-bit arithmetic gives the correct two's-complement exponent
    s1_d.exp     = EW'({2'b00, ea}) + EW'({2'b00, eb}) - EW'(BIAS);
    s1_d.prod    = PW'({1'b1, fa}) * PW'({1'b1, fb});
    s1_d.rm      = bus.rm_i;
    s1_d.is_nan  = a_nan || b_nan || inf_x_zero;
    s1_d.nv      = a_snan || b_snan || inf_x_zero;
    s1_d.is_inf  = (a_inf || b_inf) && !s1_d.is_nan;
    s1_d.is_zero = (a_zero || b_zero) && !s1_d.is_nan && !s1_d.is_inf;
  end

  // ---------------- stage 2: normalise / round / pack ----------------
  logic [PW-2:0]        norm;     // leading one dropped, fraction starts at MSB
  logic signed [EW-1:0] e_n, e_f;
  logic [PRECISION-1:0] frac_t;
  logic [PRECISION:0]   frac_r;
  logic                 g, s, inc, ovf, unf;
  logic [OW-1:0]        inf_v, max_v, nan_v;

  always_comb begin
    norm   = s1_q.prod[PW-1] ? s1_q.prod[PW-2:0] : {s1_q.prod[PW-3:0], 1'b0};
    e_n    = s1_q.exp + EW'(s1_q.prod[PW-1]);
    frac_t = norm[PW-2 -: PRECISION];
    g      = norm[PW-2-PRECISION];
    s      = |norm[PW-3-PRECISION:0];
    case (s1_q.rm)
      3'b001:  inc = 1'b0;
      3'b010:  inc = !s1_q.sign && (g || s);
      3'b011:  inc =  s1_q.sign && (g || s);
      default: inc = g && (s || frac_t[0]);
    endcase
    frac_r = {1'b0, frac_t} + {{PRECISION{1'b0}}, inc};
    // a carry-out leaves frac_r[PRECISION-1:0] at zero, only the exponent bumps
    e_f    = e_n + EW'(frac_r[PRECISION]);
    ovf    = (e_f >= EMAX_S);
    unf    = (e_f <= EZERO);

    inf_v  = {s1_q.sign, {EXPWIDTH{1'b1}}, {PRECISION{1'b0}}};
    max_v  = {s1_q.sign, {(EXPWIDTH-1){1'b1}}, 1'b0, {PRECISION{1'b1}}};
    nan_v  = {1'b0, {EXPWIDTH{1'b1}}, 1'b1, {(PRECISION-1){1'b0}}};

    res_d  = {s1_q.sign, e_f[EXPWIDTH-1:0], frac_r[PRECISION-1:0]};
    flg_d  = {4'b0000, g || s};
    if (s1_q.is_nan) begin
      res_d = nan_v;
      flg_d = {s1_q.nv, 4'b0000};
    end else if (s1_q.is_inf) begin
      res_d = inf_v;
      flg_d = '0;
    end else if (s1_q.is_zero) begin
      res_d = {s1_q.sign, {(OW-1){1'b0}}};
      flg_d = '0;
    end else if (ovf) begin
      flg_d = 5'b00101;
      case (s1_q.rm)
        3'b001:  res_d = max_v;
        3'b010:  res_d = s1_q.sign ? max_v : inf_v;
        3'b011:  res_d = s1_q.sign ? inf_v : max_v;
        default: res_d = inf_v;
      endcase
    end else if (unf) begin
      res_d = {s1_q.sign, {(OW-1){1'b0}}};
      flg_d = 5'b00011;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q     <= '0;
      vld_pipe <= '0;
      res_q    <= '0;
      flg_q    <= '0;
    end else if (bus.en_i) begin
      s1_q     <= s1_d;
      vld_pipe <= {vld_pipe[STAGES-1:1], bus.valid_i};
      res_q    <= res_d;
      flg_q    <= flg_d;
    end
  end

  assign bus.out_valid_o  = vld_pipe[STAGES];
  assign bus.out_result_o = res_q;
  assign bus.out_fflags_o = flg_q;
endmodule

// File: tb/tb_tc_mul.sv
module tb_tc_mul;
  logic clk;
  logic rst_n;

  tc_mul_if #(.EXPWIDTH(5), .INPC(10), .PRECISION(8)) bus ();

  tc_mul #(.EXPWIDTH(5), .INPC(10), .PRECISION(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  rm;
    logic [13:0] res;
    logic [4:0]  flg;
  } vec_t;

  typedef struct {
    logic [13:0] res;
    logic [4:0]  flg;
    int          idx;
  } exp_t;

  vec_t vec[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // ---------------- monitor / scoreboard ----------------
  logic        edge_en, edge_hold;
  logic        pv;
  logic [13:0] pr;
  logic [4:0]  pf;

  always @(posedge clk) begin
    exp_t e;
    edge_en   = bus.en_i && rst_n;
    edge_hold = !bus.en_i && rst_n;
    #1;
    if (edge_hold) begin
      checks++;
      if (bus.out_valid_o !== pv || bus.out_result_o !== pr || bus.out_fflags_o !== pf) begin
        errors++;
        $display("FAIL stall_hold got v=%b r=%h f=%b want v=%b r=%h f=%b",
                 bus.out_valid_o, bus.out_result_o, bus.out_fflags_o, pv, pr, pf);
      end
    end else if (edge_en && bus.out_valid_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL spurious_output got r=%h f=%b want no output", bus.out_result_o, bus.out_fflags_o);
      end else begin
        e = sb.pop_front();
        if (bus.out_result_o !== e.res || bus.out_fflags_o !== e.flg) begin
          errors++;
          $display("FAIL vec%0d got r=%h f=%b want r=%h f=%b",
                   e.idx, bus.out_result_o, bus.out_fflags_o, e.res, e.flg);
        end
      end
    end
    pv = bus.out_valid_o;
    pr = bus.out_result_o;
    pf = bus.out_fflags_o;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int i);
    @(negedge clk);
    bus.en_i    = 1'b1;
    bus.valid_i = 1'b1;
    bus.a_i     = vec[i].a;
    bus.b_i     = vec[i].b;
    bus.rm_i    = vec[i].rm;
    sb.push_back('{vec[i].res, vec[i].flg, i});
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      bus.en_i    = 1'b1;
      bus.valid_i = 1'b0;
      n++;
    end
    @(negedge clk);
    bus.valid_i = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    //              a        b        rm     result   {NV,DZ,OF,UF,NX}
    vec.push_back('{16'h3E00, 16'h4000, 3'd0, 14'h1080, 5'b00000}); // 0  1.5*2
    vec.push_back('{16'h3C01, 16'h3C01, 3'd0, 14'h0F01, 5'b00001}); // 1  g=1,s=1 RNE up
    vec.push_back('{16'h3C01, 16'h3C01, 3'd2, 14'h0F01, 5'b00001}); // 2  RUP
    vec.push_back('{16'h3C01, 16'h3C01, 3'd1, 14'h0F00, 5'b00001}); // 3  RTZ
    vec.push_back('{16'h3C01, 16'h3C01, 3'd3, 14'h0F00, 5'b00001}); // 4  RDN positive
    vec.push_back('{16'h7BFF, 16'h7BFF, 3'd0, 14'h1F00, 5'b00101}); // 5  OF RNE -> inf
    vec.push_back('{16'h7BFF, 16'h7BFF, 3'd1, 14'h1EFF, 5'b00101}); // 6  OF RTZ -> max
    vec.push_back('{16'h7BFF, 16'h7BFF, 3'd3, 14'h1EFF, 5'b00101}); // 7  OF RDN pos -> max
    vec.push_back('{16'h7BFF, 16'h7BFF, 3'd2, 14'h1F00, 5'b00101}); // 8  OF RUP pos -> inf
    vec.push_back('{16'hFBFF, 16'h7BFF, 3'd2, 14'h3EFF, 5'b00101}); // 9  OF RUP neg -> -max
    vec.push_back('{16'hFBFF, 16'h7BFF, 3'd3, 14'h3F00, 5'b00101}); // 10 OF RDN neg -> -inf
    vec.push_back('{16'h7C00, 16'h0000, 3'd0, 14'h1F80, 5'b10000}); // 11 inf*0
    vec.push_back('{16'hFC00, 16'h4000, 3'd0, 14'h3F00, 5'b00000}); // 12 -inf*2
    vec.push_back('{16'h0400, 16'h0400, 3'd0, 14'h0000, 5'b00011}); // 13 underflow
    vec.push_back('{16'h0001, 16'h4000, 3'd0, 14'h0000, 5'b00000}); // 14 subnormal DAZ
    vec.push_back('{16'h8000, 16'h4000, 3'd0, 14'h2000, 5'b00000}); // 15 -0*2
    vec.push_back('{16'h7C01, 16'h3C00, 3'd0, 14'h1F80, 5'b10000}); // 16 sNaN
    vec.push_back('{16'h7E00, 16'h3C00, 3'd0, 14'h1F80, 5'b00000}); // 17 qNaN
    vec.push_back('{16'h3C00, 16'h3C00, 3'd0, 14'h0F00, 5'b00000}); // 18 1*1 exact
    vec.push_back('{16'h3C01, 16'h3C01, 3'd7, 14'h0F01, 5'b00001}); // 19 rm 111 -> RNE
    vec.push_back('{16'h3FFF, 16'h3C00, 3'd0, 14'h1000, 5'b00001}); // 20 mantissa carry-out
    vec.push_back('{16'hBC01, 16'h3C01, 3'd3, 14'h2F01, 5'b00001}); // 21 RDN neg up
    vec.push_back('{16'hBC01, 16'h3C01, 3'd2, 14'h2F00, 5'b00001}); // 22 RUP neg trunc
    vec.push_back('{16'h0400, 16'h3C00, 3'd0, 14'h0100, 5'b00000}); // 23 e=1, no UF
    vec.push_back('{16'h7800, 16'h3C00, 3'd0, 14'h1E00, 5'b00000}); // 24 e=30, no OF
    vec.push_back('{16'h7800, 16'h4000, 3'd0, 14'h1F00, 5'b00101}); // 25 e=31 -> OF
    vec.push_back('{16'h7C00, 16'hC000, 3'd0, 14'h3F00, 5'b00000}); // 26 inf*-2
    vec.push_back('{16'h0000, 16'hFC00, 3'd0, 14'h1F80, 5'b10000}); // 27 0*-inf
    vec.push_back('{16'h3C02, 16'h3C00, 3'd0, 14'h0F00, 5'b00001}); // 28 tie, lsb 0
    vec.push_back('{16'h3C06, 16'h3C00, 3'd0, 14'h0F02, 5'b00001}); // 29 tie, lsb 1

    rst_n       = 1'b0;
    bus.en_i    = 1'b0;
    bus.valid_i = 1'b0;
    bus.rm_i    = '0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid",  32'(bus.out_valid_o),  32'd0);
    check("reset_result", 32'(bus.out_result_o), 32'd0);
    check("reset_fflags", 32'(bus.out_fflags_o), 32'd0);

    // latency: valid appears 2 enabled edges after capture
    @(negedge clk);
    rst_n = 1'b1;
    drive(0);
    @(posedge clk); #1;
    check("latency_edge1", 32'(bus.out_valid_o), 32'd0);
    @(negedge clk);
    bus.valid_i = 1'b0;
    @(posedge clk); #1;
    check("latency_edge2", 32'(bus.out_valid_o), 32'd1);
    drain();

    // table, back-to-back
    for (int i = 0; i < vec.size(); i++) drive(i);
    drain();

    // stall mid-stream with junk presented while en_i=0
    for (int i = 0; i < 4; i++) drive(i);
    repeat (3) begin
      @(negedge clk);
      bus.en_i    = 1'b0;
      bus.valid_i = 1'b1;
      bus.a_i     = 16'h4000;
      bus.b_i     = 16'h4000;
      bus.rm_i    = 3'd0;
    end
    for (int i = 4; i < 8; i++) drive(i);
    drain();

    // reset with products in flight: both discarded
    @(negedge clk);
    bus.en_i = 1'b1; bus.valid_i = 1'b1;
    bus.a_i  = vec[0].a; bus.b_i = vec[0].b; bus.rm_i = vec[0].rm;
    @(negedge clk);
    rst_n = 1'b0;
    bus.a_i = vec[1].a; bus.b_i = vec[1].b; bus.rm_i = vec[1].rm;
    @(posedge clk); #1;
    check("inflight_reset_valid",  32'(bus.out_valid_o),  32'd0);
    check("inflight_reset_result", 32'(bus.out_result_o), 32'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    bus.valid_i = 1'b0;
    @(posedge clk); #1;
    check("post_reset_idle", 32'(bus.out_valid_o), 32'd0);
    drive(20);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
